vx_mem_port_interleaver: RTL and testbench

- Sits between the last-level cache memory bus and the external memory system; generalises the single memory port to NUM_PORTS interleaved channels.
- Routes each upstream request to one channel by address-interleave bits and buffers it per channel.
- Bounds outstanding reads per channel and merges channel responses round-robin into the single upstream response stream.
- Drives a busy flag that covers all in-flight traffic.

---
 rtl/vx_mem_port_interleaver_pkg.sv | 15 +
 rtl/vx_mem_port_rsp_arb.sv | 70 +++++++
 rtl/vx_mem_port_interleaver.sv | 203 ++++++++++++++++++++
 tb/tb_vx_mem_port_interleaver.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_port_interleaver_pkg.sv
// Shared constants and width helpers for the interleaved memory-port block.
package vx_mem_port_interleaver_pkg;

   localparam int PERF_CTR_BITS = 44;

   function automatic int psel_bits(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 0;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_mem_port_rsp_arb.sv
// Round-robin merge of per-channel responses into one registered upstream stream.
module vx_mem_port_rsp_arb
   import vx_mem_port_interleaver_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_WIDTH = 512,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NUM_PORTS-1:0]                  rsp_valid_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_data_i,
   input  logic [NUM_PORTS-1:0][TAG_WIDTH-1:0]   rsp_tag_i,
   output logic [NUM_PORTS-1:0]                  rsp_ready_o,
   output logic                                  out_valid_o,
   output logic [DATA_WIDTH-1:0]                 out_data_o,
   output logic [TAG_WIDTH-1:0]                  out_tag_o,
   input  logic                                  out_ready_i
);

   localparam int IDX_W = idx_bits(NUM_PORTS);

   logic [IDX_W-1:0]      ptr_q, ptr_d, grant, idx;
   logic                  grant_vld, can_load, valid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [TAG_WIDTH-1:0]  tag_q;

   // Search starts at the pointer; first requester found wins.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = IDX_W'((int'(ptr_q) + k) % NUM_PORTS);
         if (!grant_vld && rsp_valid_i[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
      ptr_d = IDX_W'((int'(grant) + 1) % NUM_PORTS);
   end

   assign can_load = !valid_q || out_ready_i;

   always_comb begin
      rsp_ready_o = '0;
      if (grant_vld && can_load) rsp_ready_o[grant] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         tag_q   <= '0;
         ptr_q   <= '0;
      end else if (can_load) begin
         valid_q <= grant_vld;
         if (grant_vld) begin
            data_q <= rsp_data_i[grant];
            tag_q  <= rsp_tag_i[grant];
            ptr_q  <= ptr_d;
         end
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_tag_o   = tag_q;

endmodule

// File: rtl/vx_mem_port_interleaver.sv
// Splits the cache memory bus into NUM_PORTS address-interleaved channels.
// Optional per-channel performance counters under MEM_PORT_PERF_EN.
module vx_mem_port_interleaver
   import vx_mem_port_interleaver_pkg::*;
#(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_WIDTH     = 26,
   parameter int DATA_WIDTH     = 512,
   parameter int TAG_WIDTH      = 8,
   parameter int INTERLEAVE_LSB = 0,
   parameter int MAX_PENDING    = 16,
   parameter int REQ_BUF_DEPTH  = 2
) (
   input  logic                                                     clk,
   input  logic                                                     reset,
   input  logic                                                     core_req_valid,
   input  logic                                                     core_req_rw,
   input  logic [DATA_WIDTH/8-1:0]                                  core_req_byteen,
   input  logic [ADDR_WIDTH-1:0]                                    core_req_addr,
   input  logic [DATA_WIDTH-1:0]                                    core_req_data,
   input  logic [TAG_WIDTH-1:0]                                     core_req_tag,
   output logic                                                     core_req_ready,
   output logic                                                     core_rsp_valid,
   output logic [DATA_WIDTH-1:0]                                    core_rsp_data,
   output logic [TAG_WIDTH-1:0]                                     core_rsp_tag,
   input  logic                                                     core_rsp_ready,
   output logic [NUM_PORTS-1:0]                                     mem_req_valid,
   output logic [NUM_PORTS-1:0]                                     mem_req_rw,
   output logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]                   mem_req_byteen,
   output logic [NUM_PORTS-1:0][ADDR_WIDTH-psel_bits(NUM_PORTS)-1:0] mem_req_addr,
   output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]                     mem_req_data,
   output logic [NUM_PORTS-1:0][TAG_WIDTH-1:0]                      mem_req_tag,
   input  logic [NUM_PORTS-1:0]                                     mem_req_ready,
   input  logic [NUM_PORTS-1:0]                                     mem_rsp_valid,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]                     mem_rsp_data,
   input  logic [NUM_PORTS-1:0][TAG_WIDTH-1:0]                      mem_rsp_tag,
   output logic [NUM_PORTS-1:0]                                     mem_rsp_ready,
`ifdef MEM_PORT_PERF_EN
   output logic [NUM_PORTS-1:0][PERF_CTR_BITS-1:0]                  perf_reads,
   output logic [NUM_PORTS-1:0][PERF_CTR_BITS-1:0]                  perf_writes,
   output logic [NUM_PORTS-1:0][PERF_CTR_BITS-1:0]                  perf_latency,
`endif
   output logic                                                     busy,
   output logic                                                     err_underflow
);

   localparam int PSEL_BITS  = psel_bits(NUM_PORTS);
   localparam int MEM_ADDR_W = ADDR_WIDTH - PSEL_BITS;
   localparam int BE_W       = DATA_WIDTH / 8;
   localparam int PEND_W     = $clog2(MAX_PENDING + 1);
   localparam int PTR_W      = idx_bits(REQ_BUF_DEPTH);
   localparam int CNT_W      = $clog2(REQ_BUF_DEPTH + 1);

   typedef struct packed {
      logic                  rw;
      logic [BE_W-1:0]       byteen;
      logic [MEM_ADDR_W-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [TAG_WIDTH-1:0]  tag;
   } mem_port_req_t;

   logic [NUM_PORTS-1:0]             sel_hit, fifo_full, fifo_empty, push, pop, rsp_fire, undf;
   logic [NUM_PORTS-1:0][PEND_W-1:0] pend_cnt;
   logic [MEM_ADDR_W-1:0]            fwd_addr;
   logic                             req_fire, pend_any, busy_q, err_q;
   mem_port_req_t                    req_in;

   if (PSEL_BITS == 0) begin : g_single
      assign sel_hit  = 1'b1;
      assign fwd_addr = core_req_addr;
   end else begin : g_sel
      logic [PSEL_BITS-1:0] sel;
      assign sel = core_req_addr[INTERLEAVE_LSB +: PSEL_BITS];
      // Forwarded address squeezes the select field out of the line address.
      always_comb begin
         for (int i = 0; i < NUM_PORTS; i++) sel_hit[i] = (sel == PSEL_BITS'(i));
         for (int i = 0; i < MEM_ADDR_W; i++)
            fwd_addr[i] = (i < INTERLEAVE_LSB) ? core_req_addr[i] : core_req_addr[i + PSEL_BITS];
      end
   end

   always_comb begin
      core_req_ready = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (sel_hit[i])
            core_req_ready = !fifo_full[i] && (core_req_rw || (pend_cnt[i] < PEND_W'(MAX_PENDING)));
   end

   assign req_fire = core_req_valid && core_req_ready;
   assign req_in   = '{rw: core_req_rw, byteen: core_req_byteen, addr: fwd_addr,
                       data: core_req_data, tag: core_req_tag};

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ch
      mem_port_req_t     buf_q [REQ_BUF_DEPTH];
      logic [PTR_W-1:0]  wr_q, rd_q;
      logic [CNT_W-1:0]  cnt_q;
      logic [PEND_W-1:0] pend_q, pend_d;
      logic              rd_acc, undf_d;

      assign push[p]       = req_fire && sel_hit[p];
      assign pop[p]        = !fifo_empty[p] && mem_req_ready[p];
      assign fifo_empty[p] = (cnt_q == '0);
      assign fifo_full[p]  = (cnt_q == CNT_W'(REQ_BUF_DEPTH));
      assign rd_acc        = push[p] && !core_req_rw;

      always_ff @(posedge clk) begin
         if (push[p]) buf_q[wr_q] <= req_in;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push[p]) wr_q <= (wr_q == PTR_W'(REQ_BUF_DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (pop[p])  rd_q <= (rd_q == PTR_W'(REQ_BUF_DEPTH - 1)) ? '0 : rd_q + 1'b1;
            if (push[p] && !pop[p])      cnt_q <= cnt_q + 1'b1;
            else if (pop[p] && !push[p]) cnt_q <= cnt_q - 1'b1;
         end
      end

      assign mem_req_valid[p] = !fifo_empty[p];
      assign {mem_req_rw[p], mem_req_byteen[p], mem_req_addr[p], mem_req_data[p], mem_req_tag[p]} = buf_q[rd_q];

      // A response with nothing outstanding saturates at zero and flags the error.
      always_comb begin
         pend_d = pend_q;
         undf_d = 1'b0;
         if (rd_acc && !rsp_fire[p]) pend_d = pend_q + 1'b1;
         else if (!rd_acc && rsp_fire[p]) begin
            if (pend_q == '0) undf_d = 1'b1;
            else              pend_d = pend_q - 1'b1;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) pend_q <= '0;
         else        pend_q <= pend_d;
      end

      assign pend_cnt[p] = pend_q;
      assign undf[p]     = undf_d;

`ifdef MEM_PORT_PERF_EN
      logic [PERF_CTR_BITS-1:0] rd_ctr_q, wr_ctr_q, lat_ctr_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rd_ctr_q  <= '0;
            wr_ctr_q  <= '0;
            lat_ctr_q <= '0;
         end else begin
            if (pop[p] && !mem_req_rw[p]) rd_ctr_q <= rd_ctr_q + 1'b1;
            if (pop[p] && mem_req_rw[p])  wr_ctr_q <= wr_ctr_q + 1'b1;
            lat_ctr_q <= lat_ctr_q + PERF_CTR_BITS'(pend_q);
         end
      end

      assign perf_reads[p]   = rd_ctr_q;
      assign perf_writes[p]  = wr_ctr_q;
      assign perf_latency[p] = lat_ctr_q;
`endif
   end

   vx_mem_port_rsp_arb #(
      .NUM_PORTS  (NUM_PORTS),
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
   ) u_rsp_arb (
      .clk_i       (clk),
      .rst_ni      (reset),
      .rsp_valid_i (mem_rsp_valid),
      .rsp_data_i  (mem_rsp_data),
      .rsp_tag_i   (mem_rsp_tag),
      .rsp_ready_o (mem_rsp_ready),
      .out_valid_o (core_rsp_valid),
      .out_data_o  (core_rsp_data),
      .out_tag_o   (core_rsp_tag),
      .out_ready_i (core_rsp_ready)
   );

   assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

   always_comb begin
      pend_any = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) pend_any = pend_any || (pend_cnt[i] != '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= pend_any || !(&fifo_empty) || core_rsp_valid || core_req_valid;
         err_q  <= err_q || (|undf);
      end
   end

   assign busy          = busy_q;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_vx_mem_port_interleaver.sv
// Self-checking bench: vector table, directed corner sequences, and a randomized
// run against a queue-based reference model.
module tb_vx_mem_port_interleaver;

   localparam int NP = 2, AW = 26, DW = 32, TW = 8, ILSB = 0, MAXP = 4, DEPTH = 2;
   localparam int BW = DW / 8, MAW = AW - 1;

   logic clk = 1'b0, reset = 1'b0;
   logic core_req_valid, core_req_rw, core_req_ready;
   logic [BW-1:0] core_req_byteen;
   logic [AW-1:0] core_req_addr;
   logic [DW-1:0] core_req_data, core_rsp_data;
   logic [TW-1:0] core_req_tag, core_rsp_tag;
   logic core_rsp_valid, core_rsp_ready;
   logic [NP-1:0] mem_req_valid, mem_req_rw, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
   logic [NP-1:0][BW-1:0]  mem_req_byteen;
   logic [NP-1:0][MAW-1:0] mem_req_addr;
   logic [NP-1:0][DW-1:0]  mem_req_data, mem_rsp_data;
   logic [NP-1:0][TW-1:0]  mem_req_tag, mem_rsp_tag;
   logic busy, err_underflow;
`ifdef MEM_PORT_PERF_EN
   logic [NP-1:0][43:0] perf_reads, perf_writes, perf_latency;
`endif

   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   vx_mem_port_interleaver #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
      .INTERLEAVE_LSB(ILSB), .MAX_PENDING(MAXP), .REQ_BUF_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
      .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
      .core_req_data(core_req_data), .core_req_tag(core_req_tag),
      .core_req_ready(core_req_ready),
      .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
      .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
      .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
`ifdef MEM_PORT_PERF_EN
      .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_latency(perf_latency),
`endif
      .busy(busy), .err_underflow(err_underflow)
   );

   typedef struct {
      logic           rw;
      logic [AW-1:0]  addr;
      int             ch;
      logic [MAW-1:0] fwd;
   } vec_t;

   typedef struct {
      logic           rw;
      logic [BW-1:0]  be;
      logic [MAW-1:0] addr;
      logic [DW-1:0]  data;
      logic [TW-1:0]  tag;
   } mreq_t;

   mreq_t mq [NP][$];
   int    mpend [NP];
   int    mptr;
   logic  mov, mbusy, merr;
   logic [DW-1:0] mdata;
   logic [TW-1:0] mtag;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_byteen = '1;
      core_req_addr = '0; core_req_data = '0; core_req_tag = '0;
      core_rsp_ready = 1'b1; mem_req_ready = '0; mem_rsp_valid = '0;
      mem_rsp_data = '0; mem_rsp_tag = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      for (int c = 0; c < NP; c++) begin
         mq[c].delete();
         mpend[c] = 0;
      end
      mptr = 0; mov = 1'b0; mbusy = 1'b0; merr = 1'b0; mdata = '0; mtag = '0;
   endtask

   task automatic send(input logic rw, input logic [AW-1:0] a);
      core_req_valid = 1'b1; core_req_rw = rw; core_req_addr = a;
   endtask

   function automatic int ch_of(input logic [AW-1:0] a);
      return int'((a >> ILSB) % NP);
   endfunction

   function automatic logic [MAW-1:0] fwd_of(input logic [AW-1:0] a);
      logic [AW-1:0] lo, hi;
      lo = a & ((AW'(1) << ILSB) - AW'(1));
      hi = (a >> (ILSB + 1)) << ILSB;
      return MAW'(hi | lo);
   endfunction

   initial begin
      vec_t  vt [6];
      mreq_t e;
      int    p, g, idx;
      logic  exp_rdy, canld, nbusy, inc, dec;
      logic [NP-1:0] exp_mrr;

      vt[0] = '{1'b0, 26'h0000010, 0, 25'h0000008};
      vt[1] = '{1'b0, 26'h0000011, 1, 25'h0000008};
      vt[2] = '{1'b1, 26'h3FFFFFF, 1, 25'h1FFFFFF};
      vt[3] = '{1'b1, 26'h0000000, 0, 25'h0000000};
      vt[4] = '{1'b1, 26'h2AAAAAA, 0, 25'h1555555};
      vt[5] = '{1'b1, 26'h1555555, 1, 25'h0AAAAAA};

      idle();
      #2;
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_core_rsp_valid", core_rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_underflow, 0);
      do_reset();

      // Address split and 1-cycle accept-to-valid latency
      mem_req_ready = '1;
      for (int i = 0; i < 6; i++) begin
         send(vt[i].rw, vt[i].addr);
         core_req_tag = TW'(i);
         core_req_data = DW'(32'hC0DE_0000 + i);
         @(negedge clk);
         check("tbl_ready", core_req_ready, 1);
         tick();
         core_req_valid = 1'b0;
         @(negedge clk);
         check("tbl_valid", mem_req_valid, 64'(1) << vt[i].ch);
         check("tbl_addr", mem_req_addr[vt[i].ch], vt[i].fwd);
         check("tbl_tag", mem_req_tag[vt[i].ch], i);
         check("tbl_rw", mem_req_rw[vt[i].ch], vt[i].rw);
         tick();
      end

      // Reset mid-traffic
      do_reset();
      mem_req_ready = '0;
      send(1'b0, 26'h2); tick();
      send(1'b0, 26'h3); tick();
      send(1'b0, 26'h4); tick();
      core_req_valid = 1'b0;
      @(negedge clk);
      check("mid_pre_valid", mem_req_valid, 2'b11);
      check("mid_pre_busy", busy, 1);
      tick();
      reset = 1'b0;
      #1;
      check("mid_rst_valid", mem_req_valid, 0);
      check("mid_rst_rsp_valid", core_rsp_valid, 0);
      check("mid_rst_busy", busy, 0);
      repeat (2) tick();
      reset = 1'b1;
      mem_req_ready = '1;
      tick(); tick();
      check("mid_post_busy", busy, 0);
      check("mid_post_valid", mem_req_valid, 0);

      // Pending limit on channel 0 (also shows pending was cleared by reset)
      for (int i = 0; i < 5; i++) begin
         send(1'b0, AW'(2 * (i + 1)));
         @(negedge clk);
         check("pend_read_ready", core_req_ready, (i < 4) ? 1 : 0);
         tick();
      end
      @(negedge clk);
      check("pend_held_ready", core_req_ready, 0);
      tick();
      send(1'b1, 26'h20);
      @(negedge clk);
      check("pend_write_ch0_ready", core_req_ready, 1);
      tick();
      send(1'b0, 26'h21);
      @(negedge clk);
      check("pend_read_ch1_ready", core_req_ready, 1);
      tick();
      send(1'b0, 26'h0A);
      mem_rsp_valid = 2'b01;
      mem_rsp_tag[0] = 8'h55;
      @(negedge clk);
      check("pend_rsp_cycle_ready", core_req_ready, 0);
      check("pend_rsp_mem_ready", mem_rsp_ready, 2'b01);
      tick();
      mem_rsp_valid = '0;
      @(negedge clk);
      check("pend_reenabled_ready", core_req_ready, 1);
      check("pend_rsp_tag", core_rsp_tag, 8'h55);
      tick();
      core_req_valid = 1'b0;

      // Round-robin merge and backpressure hold
      do_reset();
      mem_rsp_valid = 2'b11;
      mem_rsp_tag[0] = 8'd0; mem_rsp_tag[1] = 8'd1;
      mem_rsp_data[0] = 32'hA0A0_A0A0; mem_rsp_data[1] = 32'hB1B1_B1B1;
      core_rsp_ready = 1'b1;
      @(negedge clk);
      check("rr_first_grant", mem_rsp_ready, 2'b01);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_valid", core_rsp_valid, 1);
         check("rr_tag", core_rsp_tag, i % 2);
         check("rr_data", core_rsp_data, (i % 2) ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0);
      end
      core_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_mem_rsp_ready", mem_rsp_ready, 0);
         check("hold_tag", core_rsp_tag, 1);
         check("hold_data", core_rsp_data, 32'hB1B1_B1B1);
         check("hold_valid", core_rsp_valid, 1);
         tick();
      end

      // Same-cycle accept and response on channel 1 keeps pending at 2
      do_reset();
      mem_req_ready = '1;
      core_rsp_ready = 1'b1;
      send(1'b0, 26'h1); tick();
      send(1'b0, 26'h3); tick();
      send(1'b0, 26'h5);
      mem_rsp_valid = 2'b10;
      @(negedge clk);
      check("same_ready", core_req_ready, 1);
      check("same_mem_rsp_ready", mem_rsp_ready, 2'b10);
      tick();
      core_req_valid = 1'b0;
      mem_rsp_valid = '0;
      tick();
      for (int i = 0; i < 2; i++) begin
         mem_rsp_valid = 2'b10; tick();
         mem_rsp_valid = '0;    tick();
      end
      check("same_no_underflow", err_underflow, 0);
      mem_rsp_valid = 2'b10; tick();
      mem_rsp_valid = '0;
      check("same_third_underflow", err_underflow, 1);

      // Underflow on channel 0 with nothing pending
      do_reset();
      check("undf_clear_after_rst", err_underflow, 0);
      mem_rsp_valid = 2'b01; tick();
      mem_rsp_valid = '0;
      check("undf_set", err_underflow, 1);
      repeat (3) tick();
      check("undf_sticky", err_underflow, 1);
      // Counter saturated at zero, so four reads still fit
      mem_req_ready = '1;
      for (int i = 0; i < 4; i++) begin
         send(1'b0, AW'(2 * i));
         @(negedge clk);
         check("undf_sat_ready", core_req_ready, 1);
         tick();
      end
      core_req_valid = 1'b0;

      // Randomized run against the reference model
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         core_req_valid  = 1'($urandom_range(0, 1));
         core_req_rw     = ($urandom_range(0, 3) == 0);
         core_req_addr   = AW'($urandom);
         core_req_byteen = BW'($urandom);
         core_req_data   = DW'($urandom);
         core_req_tag    = TW'($urandom);
         core_rsp_ready  = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < NP; c++) begin
            mem_req_ready[c] = ($urandom_range(0, 3) != 0);
            mem_rsp_valid[c] = (mpend[c] > 0 || $urandom_range(0, 15) == 0) && ($urandom_range(0, 1) == 1);
            mem_rsp_data[c]  = DW'($urandom);
            mem_rsp_tag[c]   = TW'($urandom);
         end
         @(negedge clk);

         p = ch_of(core_req_addr);
         exp_rdy = (mq[p].size() < DEPTH) && (core_req_rw || mpend[p] < MAXP);
         check("rnd_req_ready", core_req_ready, exp_rdy);
         for (int c = 0; c < NP; c++) begin
            check("rnd_mem_req_valid", mem_req_valid[c], mq[c].size() > 0);
            if (mq[c].size() > 0) begin
               e = mq[c][0];
               check("rnd_mem_req_addr", mem_req_addr[c], e.addr);
               check("rnd_mem_req_tag", mem_req_tag[c], e.tag);
               check("rnd_mem_req_rw", mem_req_rw[c], e.rw);
               check("rnd_mem_req_data", mem_req_data[c], e.data);
               check("rnd_mem_req_byteen", mem_req_byteen[c], e.be);
            end
         end
         g = -1;
         for (int k = 0; k < NP; k++) begin
            idx = (mptr + k) % NP;
            if (g < 0 && mem_rsp_valid[idx]) g = idx;
         end
         canld = !mov || core_rsp_ready;
         exp_mrr = (g >= 0 && canld) ? NP'(1 << g) : '0;
         check("rnd_mem_rsp_ready", mem_rsp_ready, exp_mrr);
         check("rnd_rsp_valid", core_rsp_valid, mov);
         if (mov) begin
            check("rnd_rsp_tag", core_rsp_tag, mtag);
            check("rnd_rsp_data", core_rsp_data, mdata);
         end
         check("rnd_busy", busy, mbusy);
         check("rnd_err", err_underflow, merr);

         nbusy = core_req_valid || mov;
         for (int c = 0; c < NP; c++) nbusy = nbusy || (mq[c].size() > 0) || (mpend[c] != 0);
         for (int c = 0; c < NP; c++)
            if (mq[c].size() > 0 && mem_req_ready[c]) void'(mq[c].pop_front());
         if (core_req_valid && exp_rdy) begin
            e.rw = core_req_rw; e.be = core_req_byteen; e.addr = fwd_of(core_req_addr);
            e.data = core_req_data; e.tag = core_req_tag;
            mq[p].push_back(e);
         end
         for (int c = 0; c < NP; c++) begin
            inc = core_req_valid && exp_rdy && !core_req_rw && (p == c);
            dec = exp_mrr[c];
            if (inc && !dec) mpend[c]++;
            else if (dec && !inc) begin
               if (mpend[c] == 0) merr = 1'b1;
               else               mpend[c]--;
            end
         end
         if (canld) begin
            mov = (g >= 0);
            if (g >= 0) begin
               mtag  = mem_rsp_tag[g];
               mdata = mem_rsp_data[g];
               mptr  = (g + 1) % NP;
            end
         end
         mbusy = nbusy;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
